divider: RTL and testbench

- Multi-cycle fixed-point divider; the inverse operation of the `multiplier` block. It uses the same operand format, the same `signed_cal` sign handling and the same `trigger`/`ready`/`done` handshake.
- Computes quotient `y = (a << FIXED_POINT) / b` and remainder `r`, using restoring shift-subtract on magnitudes.
- Serves the synth datapath wherever a ratio is needed: envelope slope = delta / steps, and frequency-to-increment conversion.

---
 rtl/divider_if.sv | 28 ++
 rtl/divider.sv | 184 ++++++++++++++++++
 tb/tb_divider.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Operand/result bundle for the fixed-point divider.
// Handshake: a request is accepted on a rising edge where trigger=1 and ready=1;
// done pulses for one cycle when y, r and the flags are valid, and they hold until the next result.
interface divider_if #(
  parameter int C_WIDTH = 32
);
  logic [C_WIDTH-1:0] a;
  logic [C_WIDTH-1:0] b;
  logic               signed_cal;
  logic               trigger;
  logic               ready;
  logic               done;
  logic [C_WIDTH-1:0] y;
  logic [C_WIDTH-1:0] r;
  logic               div_by_zero;
  logic               overflow;
  logic [1:0]         dbg_state;

  modport master (
    output a, b, signed_cal, trigger,
    input  ready, done, y, r, div_by_zero, overflow, dbg_state
  );

  modport slave (
    input  a, b, signed_cal, trigger,
    output ready, done, y, r, div_by_zero, overflow, dbg_state
  );
endinterface

// File: rtl/divider.sv
// Multi-cycle fixed-point divider: y = (a << FIXED_POINT) / b with remainder r,
// restoring shift-subtract on magnitudes, saturating quotient.
module divider #(
  parameter int C_WIDTH     = 32,
  parameter int FIXED_POINT = 8,
  parameter int USE_CLA     = 1
) (
  input  logic     ctl_clk,
  input  logic     reset,
  divider_if.slave bus
);
  localparam int N  = C_WIDTH + FIXED_POINT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]      N_CNT = CW'(N);
  localparam logic [C_WIDTH-1:0] ONES  = '1;
  localparam logic [C_WIDTH-1:0] SMIN  = {1'b1, {(C_WIDTH-1){1'b0}}};
  localparam logic [C_WIDTH-1:0] SMAX  = {1'b0, {(C_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N-1:0]       dvd_q, dvd_d;
  logic [N-1:0]       quo_q, quo_d;
  logic [C_WIDTH:0]   p_q, p_d;
  logic [C_WIDTH-1:0] amag_q, amag_d, bmag_q, bmag_d;
  logic               sgn_q, sgn_d, qsign_q, qsign_d, rsign_q, rsign_d, bzero_q, bzero_d;
  logic [C_WIDTH-1:0] y_q, y_d, r_q, r_d;
  logic               dbz_q, dbz_d, ovf_q, ovf_d;

  // Trial subtraction: p_sh - |b| as p_sh + ~|b| + 1; no borrow when carry-out is 1.
  logic [C_WIDTH:0]   p_sh, b_inv, diff;
  logic               cout;
  logic               p_msb_unused;

  assign p_sh  = {p_q[C_WIDTH-1:0], dvd_q[N-1]};
  assign b_inv = ~{1'b0, bmag_q};
  // P is always below |b| between iterations, so its top bit never feeds the next shift.
  assign p_msb_unused = p_q[C_WIDTH];

  generate
    if (USE_CLA != 0) begin : g_cla
      assign {cout, diff} = {1'b0, p_sh} + {1'b0, b_inv} + {{(C_WIDTH+1){1'b0}}, 1'b1};
    end else begin : g_rca
      logic [C_WIDTH+1:0] c;
      always_comb begin
        c    = '0;
        c[0] = 1'b1;
        diff = '0;
        for (int i = 0; i <= C_WIDTH; i++) begin
          diff[i]  = p_sh[i] ^ b_inv[i] ^ c[i];
          c[i+1]   = (p_sh[i] & b_inv[i]) | (c[i] & (p_sh[i] ^ b_inv[i]));
        end
      end
      assign cout = c[C_WIDTH+1];
    end
  endgenerate

  logic [C_WIDTH-1:0] q_lo, rem, y_fix, r_fix;
  logic               q_hi, ovf_fix;

  always_comb begin
    q_lo    = quo_q[C_WIDTH-1:0];
    q_hi    = |quo_q[N-1:C_WIDTH];
    rem     = p_q[C_WIDTH-1:0];
    y_fix   = q_lo;
    ovf_fix = 1'b0;
    r_fix   = rsign_q ? -rem : rem;
    if (bzero_q) begin
      // rsign_q with the latched magnitude rebuilds the original a.
      r_fix = rsign_q ? -amag_q : amag_q;
      y_fix = !sgn_q ? ONES : (rsign_q ? SMIN : SMAX);
    end else if (!sgn_q) begin
      if (q_hi) begin
        ovf_fix = 1'b1;
        y_fix   = ONES;
      end
    end else if (q_hi || (q_lo > SMIN) || ((q_lo == SMIN) && !qsign_q)) begin
      ovf_fix = 1'b1;
      y_fix   = qsign_q ? SMIN : SMAX;
    end else if (qsign_q) begin
      y_fix = -q_lo;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    p_d     = p_q;
    amag_d  = amag_q;
    bmag_d  = bmag_q;
    sgn_d   = sgn_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    bzero_d = bzero_q;
    y_d     = y_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.trigger) begin
          amag_d  = (bus.signed_cal && bus.a[C_WIDTH-1]) ? -bus.a : bus.a;
          bmag_d  = (bus.signed_cal && bus.b[C_WIDTH-1]) ? -bus.b : bus.b;
          sgn_d   = bus.signed_cal;
          qsign_d = (bus.a[C_WIDTH-1] ^ bus.b[C_WIDTH-1]) & bus.signed_cal;
          rsign_d = bus.a[C_WIDTH-1] & bus.signed_cal;
          bzero_d = (bus.b == '0);
          dvd_d   = {amag_d, {FIXED_POINT{1'b0}}};
          quo_d   = '0;
          p_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // The cycle after the last iteration hands over to FIX.
        if (cnt_q == N_CNT) begin
          state_d = FIX;
        end else begin
          dvd_d = {dvd_q[N-2:0], 1'b0};
          quo_d = {quo_q[N-2:0], cout};
          p_d   = cout ? diff : p_sh;
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        y_d     = y_fix;
        r_d     = r_fix;
        dbz_d   = bzero_q;
        ovf_d   = ovf_fix;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ctl_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      p_q     <= '0;
      amag_q  <= '0;
      bmag_q  <= '0;
      sgn_q   <= 1'b0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      bzero_q <= 1'b0;
      y_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      p_q     <= p_d;
      amag_q  <= amag_d;
      bmag_q  <= bmag_d;
      sgn_q   <= sgn_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      bzero_q <= bzero_d;
      y_q     <= y_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.y           = y_q;
  assign bus.r           = r_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_divider.sv
// Bench for divider: ripple and lookahead variants side by side, directed vectors,
// expected results queued at issue and checked by per-instance monitors on done.
module tb_divider;
  localparam int W   = 32;
  localparam int LAT = W + 8 + 2;

  logic ctl_clk = 1'b0;
  logic reset   = 1'b0;

  divider_if #(.C_WIDTH(W)) bus0 ();
  divider_if #(.C_WIDTH(W)) bus1 ();

  divider #(.C_WIDTH(W), .FIXED_POINT(8), .USE_CLA(0)) dut0 (
    .ctl_clk(ctl_clk), .reset(reset), .bus(bus0.slave)
  );
  divider #(.C_WIDTH(W), .FIXED_POINT(8), .USE_CLA(1)) dut1 (
    .ctl_clk(ctl_clk), .reset(reset), .bus(bus1.slave)
  );

  // clock / reset
  always #5 ctl_clk = ~ctl_clk;
  int cyc = 0;
  always @(posedge ctl_clk) cyc++;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W+1:0] exp_q0[$];
  logic [2*W+1:0] exp_q1[$];
  int             due_q0[$];
  int             due_q1[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitors
  task automatic mon(input int id, input logic [2*W+1:0] act);
    logic [2*W+1:0] e;
    int due;
    if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_done dut%0d: got done with %h, required no done (cycle %0d)", id, act, cyc);
      return;
    end
    if (id == 0) begin
      e = exp_q0.pop_front(); due = due_q0.pop_front();
    end else begin
      e = exp_q1.pop_front(); due = due_q1.pop_front();
    end
    chk($sformatf("result_dut%0d {y,r,dbz,ovf}", id), 128'(act), 128'(e));
    chk($sformatf("latency_dut%0d done_cycle", id), 128'(cyc), 128'(due));
  endtask

  always @(negedge ctl_clk)
    if (bus0.done) mon(0, {bus0.y, bus0.r, bus0.div_by_zero, bus0.overflow});
  always @(negedge ctl_clk)
    if (bus1.done) mon(1, {bus1.y, bus1.r, bus1.div_by_zero, bus1.overflow});

  // drivers
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic t);
    bus0.a = a; bus1.a = a;
    bus0.b = b; bus1.b = b;
    bus0.signed_cal = s; bus1.signed_cal = s;
    bus0.trigger = t; bus1.trigger = t;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!(bus0.ready && bus1.ready) && k < 200) begin
      @(negedge ctl_clk);
      k++;
    end
    if (!(bus0.ready && bus1.ready)) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got ready=%b%b, required 11", bus0.ready, bus1.ready);
    end
  endtask

  task automatic push_exp(input logic [2*W+1:0] e, input int due);
    exp_q0.push_back(e); due_q0.push_back(due);
    exp_q1.push_back(e); due_q1.push_back(due);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit push, input logic [2*W+1:0] e);
    wait_ready();
    drive(a, b, s, 1'b1);
    @(posedge ctl_clk);
    @(negedge ctl_clk);
    // scramble inputs: the running operation must not see them
    drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    chk("busy_after_trigger ready", 128'({bus0.ready, bus1.ready}), 128'(0));
    if (push) push_exp(e, cyc + LAT);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input logic [W-1:0] y, input logic [W-1:0] r, input logic dbz, input logic ovf);
    start_op(a, b, s, 1'b1, {y, r, dbz, ovf});
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " dut0 {ready,done,y,r,dbz,ovf}"},
        128'({bus0.ready, bus0.done, bus0.y, bus0.r, bus0.div_by_zero, bus0.overflow}),
        128'({1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}));
    chk({name, " dut1 {ready,done,y,r,dbz,ovf}"},
        128'({bus1.ready, bus1.done, bus1.y, bus1.r, bus1.div_by_zero, bus1.overflow}),
        128'({1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}));
  endtask

  initial begin
    drive('0, '0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1 chk_reset_vals("reset_state");
    repeat (3) @(negedge ctl_clk);
    reset = 1'b0;

    //  a             b             s     y             r             dbz   ovf
    run(32'h00000300, 32'h00000200, 1'b0, 32'h00000180, 32'h00000000, 1'b0, 1'b0);
    run(32'hFFFFFD00, 32'h00000200, 1'b1, 32'hFFFFFE80, 32'h00000000, 1'b0, 1'b0);
    run(32'hFFFFFD00, 32'hFFFFFE00, 1'b1, 32'h00000180, 32'h00000000, 1'b0, 1'b0);
    run(32'h00000100, 32'h00000300, 1'b0, 32'h00000055, 32'h00000100, 1'b0, 1'b0);
    run(32'hFFFFFF00, 32'h00000300, 1'b1, 32'hFFFFFFAB, 32'hFFFFFF00, 1'b0, 1'b0);
    run(32'h00000100, 32'hFFFFFD00, 1'b1, 32'hFFFFFFAB, 32'h00000100, 1'b0, 1'b0);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000100, 32'h00000000, 1'b0, 1'b0);
    run(32'h00000100, 32'h00000000, 1'b0, 32'hFFFFFFFF, 32'h00000100, 1'b1, 1'b0);
    run(32'hFFFFFF00, 32'h00000000, 1'b1, 32'h80000000, 32'hFFFFFF00, 1'b1, 1'b0);
    run(32'h00000100, 32'h00000000, 1'b1, 32'h7FFFFFFF, 32'h00000100, 1'b1, 1'b0);
    run(32'h01000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
    run(32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1);
    run(32'hFF800000, 32'h00000001, 1'b1, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
    run(32'h80000000, 32'h00000001, 1'b1, 32'h80000000, 32'h00000000, 1'b0, 1'b1);

    // trigger pulsed mid-CALC must be ignored
    run(32'h00000300, 32'h00000200, 1'b0, 32'h00000180, 32'h00000000, 1'b0, 1'b0);
    repeat (10) @(negedge ctl_clk);
    drive(32'h00000100, 32'h00000000, 1'b1, 1'b1);
    @(negedge ctl_clk);
    drive(32'h00000100, 32'h00000000, 1'b1, 1'b0);

    // trigger held high: a new operation starts at each IDLE visit
    wait_ready();
    drive(32'h00000100, 32'h00000300, 1'b0, 1'b1);
    @(posedge ctl_clk);
    @(negedge ctl_clk);
    push_exp({32'h00000055, 32'h00000100, 1'b0, 1'b0}, cyc + LAT);
    wait_ready();
    push_exp({32'h00000055, 32'h00000100, 1'b0, 1'b0}, cyc + 1 + LAT);
    @(posedge ctl_clk);
    @(negedge ctl_clk);
    drive(32'h00000000, 32'h00000000, 1'b0, 1'b0);

    // reset mid-CALC aborts with no done pulse
    start_op(32'h00000300, 32'h00000200, 1'b0, 1'b0, '0);
    repeat (10) @(negedge ctl_clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("reset_mid_calc");
    @(negedge ctl_clk);
    reset = 1'b0;
    repeat (60) @(negedge ctl_clk);
    run(32'hFFFFFF00, 32'h00000300, 1'b1, 32'hFFFFFFAB, 32'hFFFFFF00, 1'b0, 1'b0);

    for (int i = 0; i < 200 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++)
      @(negedge ctl_clk);
    chk("drain pending_results", 128'(exp_q0.size() + exp_q1.size()), 128'(0));
    repeat (5) @(negedge ctl_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
